// File: rtl/spi_board_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_board_pkg
//  Description : Shared constants and types for the two-stage SPI board.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_board_pkg;

    localparam int STAGE_W   = 8;
    localparam int CHAIN_LEN = 2;

    // Segment bit positions inside the segment stage's latched byte
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef logic [STAGE_W-1:0] stage_t;

endpackage
`default_nettype wire

// File: rtl/spi_board_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_board_if
//  Description : Three-wire SPI bus (slave select, MOSI, MISO).
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_board_if;

    logic ss;
    logic mosi;
    logic miso;

    modport master (output ss, output mosi, input miso);
    modport slave  (input ss, input mosi, output miso);

endinterface
`default_nettype wire

// File: rtl/spi_board_stage.sv
`default_nettype none
// ============================================================================
//  Module      : spi_stage
//  Description : One 8-bit daisy-chain stage: shift register with serial out
//                and an output latch loaded on the slave-select rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_stage
    import spi_board_pkg::*;
(
    input  wire    clk,
    input  wire    rst,
    input  wire    i_ss,
    input  wire    i_ser,
    output logic   o_ser,
    output stage_t o_par
);

    stage_t r_sr;
    stage_t r_q;
    logic   r_ss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr   <= '0;
            r_q    <= '0;
            r_ss_q <= 1'b1;
        end else begin
            r_ss_q <= i_ss;
            if (!i_ss) begin
                r_sr <= {r_sr[STAGE_W-2:0], i_ser};
            end
            // Load only on the first ss-high edge after a low period
            if (!r_ss_q && i_ss) begin
                r_q <= r_sr;
            end
        end
    end

    assign o_ser = r_sr[STAGE_W-1];
    assign o_par = r_q;

endmodule
`default_nettype wire

// File: rtl/spi_board.sv
`default_nettype none
// ============================================================================
//  Module      : spi_board
//  Description : SPI peripheral board: 7-segment stage chained to a motor
//                stage, switch readback on MISO, PWM-gated tri-state outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_board
    import spi_board_pkg::*;
(
    input  wire         sclk,
    input  wire         rst,
    spi_board_if.slave  bus,
    input  wire         in1,
    input  wire         in2,
    input  wire         in3,
    input  wire         in4,
    input  wire         in5,
    input  wire         in6,
    input  wire         in7,
    input  wire         in8,
    output logic        la,
    output logic        lb,
    output logic        lc,
    output logic        ld,
    output logic        le,
    output logic        lf,
    output logic        lg,
    output logic        ldp,
    output logic        sc1,
    output logic        sc2,
    output logic        sc3,
    output logic        sc4,
    output logic        sc5,
    output logic        sc6,
    output logic        sc7,
    output logic        sc8,
    input  wire         pwm,
    output wire         out1,
    output wire         out2,
    output wire         out3,
    output wire         out4,
    output wire         out5,
    output wire         out6,
    output wire         out7,
    output wire         out8
);

    logic   w_seg_ser;
    logic   w_mtr_ser;
    stage_t w_seg_q;
    stage_t w_mtr_q;
    stage_t w_in;
    stage_t r_in_sr;
    stage_t r_sc;

    spi_stage u_seg (
        .clk   (sclk),
        .rst   (rst),
        .i_ss  (bus.ss),
        .i_ser (bus.mosi),
        .o_ser (w_seg_ser),
        .o_par (w_seg_q)
    );

    spi_stage u_mtr (
        .clk   (sclk),
        .rst   (rst),
        .i_ss  (bus.ss),
        .i_ser (w_seg_ser),
        .o_ser (w_mtr_ser),
        .o_par (w_mtr_q)
    );

    // Bits shifted past the motor stage are discarded
    logic w_unused;
    assign w_unused = w_mtr_ser;

    assign w_in = {in1, in2, in3, in4, in5, in6, in7, in8};

    // The motor stage has no inputs, so zeros follow the switch byte
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_in_sr <= '0;
            r_sc    <= '0;
        end else begin
            r_sc <= w_in;
            if (bus.ss) begin
                r_in_sr <= w_in;
            end else begin
                r_in_sr <= {r_in_sr[STAGE_W-2:0], 1'b0};
            end
        end
    end

    assign bus.miso = r_in_sr[STAGE_W-1];

    assign {sc1, sc2, sc3, sc4, sc5, sc6, sc7, sc8} = r_sc;

    assign la  = w_seg_q[SEG_A];
    assign lb  = w_seg_q[SEG_B];
    assign lc  = w_seg_q[SEG_C];
    assign ld  = w_seg_q[SEG_D];
    assign le  = w_seg_q[SEG_E];
    assign lf  = w_seg_q[SEG_F];
    assign lg  = w_seg_q[SEG_G];
    assign ldp = w_seg_q[SEG_DP];

    assign out1 = pwm ? w_mtr_q[0] : 1'bz;
    assign out2 = pwm ? w_mtr_q[1] : 1'bz;
    assign out3 = pwm ? w_mtr_q[2] : 1'bz;
    assign out4 = pwm ? w_mtr_q[3] : 1'bz;
    assign out5 = pwm ? w_mtr_q[4] : 1'bz;
    assign out6 = pwm ? w_mtr_q[5] : 1'bz;
    assign out7 = pwm ? w_mtr_q[6] : 1'bz;
    assign out8 = pwm ? w_mtr_q[7] : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_spi_board.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_board
//  Description : Directed self-checking bench for spi_board.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_board;

    logic sclk;
    logic rst;
    logic pwm;
    logic [7:0] r_in;   // r_in[7] drives in1 ... r_in[0] drives in8

    wire la, lb, lc, ld, le, lf, lg, ldp;
    wire sc1, sc2, sc3, sc4, sc5, sc6, sc7, sc8;
    wire out1, out2, out3, out4, out5, out6, out7, out8;

    // Released outputs float to 1 so a disabled driver is observable
    pullup (out1);
    pullup (out2);
    pullup (out3);
    pullup (out4);
    pullup (out5);
    pullup (out6);
    pullup (out7);
    pullup (out8);

    int n_pass;
    int n_total;

    spi_board_if bus ();

    spi_board dut (
        .sclk (sclk), .rst (rst), .bus (bus.slave),
        .in1 (r_in[7]), .in2 (r_in[6]), .in3 (r_in[5]), .in4 (r_in[4]),
        .in5 (r_in[3]), .in6 (r_in[2]), .in7 (r_in[1]), .in8 (r_in[0]),
        .la (la), .lb (lb), .lc (lc), .ld (ld),
        .le (le), .lf (lf), .lg (lg), .ldp (ldp),
        .sc1 (sc1), .sc2 (sc2), .sc3 (sc3), .sc4 (sc4),
        .sc5 (sc5), .sc6 (sc6), .sc7 (sc7), .sc8 (sc8),
        .pwm (pwm),
        .out1 (out1), .out2 (out2), .out3 (out3), .out4 (out4),
        .out5 (out5), .out6 (out6), .out7 (out7), .out8 (out8)
    );

    wire [7:0] w_seg = {ldp, lg, lf, le, ld, lc, lb, la};
    wire [7:0] w_out = {out8, out7, out6, out5, out4, out3, out2, out1};
    wire [7:0] w_sc  = {sc1, sc2, sc3, sc4, sc5, sc6, sc7, sc8};

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic idle(input int n);
        repeat (n) @(negedge sclk);
    endtask

    // Shifts w[n-1:0] MSB first, capturing MISO before each rising edge
    task automatic shift_bits(input logic [15:0] w, input int n, output logic [15:0] cap);
        cap = '0;
        bus.ss = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            bus.mosi = w[i];
            #1 cap[i] = bus.miso;
            @(negedge sclk);
        end
    endtask

    task automatic end_xfer;
        bus.ss = 1'b1;
        @(negedge sclk);
    endtask

    task automatic xfer(input logic [15:0] w, output logic [15:0] cap);
        shift_bits(w, 16, cap);
        end_xfer();
    endtask

    task automatic test_reset;
        logic [15:0] cap;
        rst = 1'b1; pwm = 1'b1; r_in = 8'h80;
        idle(2);
        rst = 1'b0;
        n_total++;
        if (bus.miso !== 1'b0) $display("FAIL reset_miso actual=%b required=0", bus.miso);
        else n_pass++;
        n_total++;
        if ({w_out, w_seg, w_sc} !== 24'h0) $display("FAIL reset_regs actual out=%h seg=%h sc=%h required 00/00/00", w_out, w_seg, w_sc);
        else n_pass++;
        idle(1);
        n_total++;
        if (bus.miso !== 1'b1) $display("FAIL reset_miso_load actual=%b required=1", bus.miso);
        else n_pass++;
        r_in = 8'h00;
        idle(1);
        xfer(16'h0000, cap);
        n_total++;
        if ({w_out, w_seg, w_sc} !== 24'h0) $display("FAIL reset_xfer0 actual out=%h seg=%h sc=%h required 00/00/00", w_out, w_seg, w_sc);
        else n_pass++;
    endtask

    task automatic test_word;
        logic [15:0] cap;
        shift_bits(16'h1bcf, 16, cap);
        n_total++;
        if ({w_out, w_seg} !== 16'h0000) $display("FAIL word_pre_latch actual=%h required=0000", {w_out, w_seg});
        else n_pass++;
        end_xfer();
        n_total++;
        if (w_seg !== 8'hcf) $display("FAIL word_seg actual=%h required=cf", w_seg);
        else n_pass++;
        n_total++;
        if (w_out !== 8'h1b) $display("FAIL word_out actual=%h required=1b", w_out);
        else n_pass++;
    endtask

    task automatic test_pwm;
        pwm = 1'b0;
        #1;
        n_total++;
        if (w_out !== 8'hff) $display("FAIL pwm_off actual=%h required=ff(released)", w_out);
        else n_pass++;
        idle(2);
        pwm = 1'b1;
        #1;
        n_total++;
        if (w_out !== 8'h1b) $display("FAIL pwm_restore actual=%h required=1b", w_out);
        else n_pass++;
        @(negedge sclk);
    endtask

    task automatic test_inputs;
        logic [15:0] cap;
        r_in = 8'h20;            // in3
        idle(2);
        xfer(16'h1bcf, cap);
        n_total++;
        if (cap !== 16'h2000) $display("FAIL in3_capture actual=%h required=2000", cap);
        else n_pass++;
        n_total++;
        if (w_sc !== 8'h20) $display("FAIL in3_sc actual=%h required=20", w_sc);
        else n_pass++;
        r_in = 8'h01;            // in8
        idle(2);
        xfer(16'h1bcf, cap);
        n_total++;
        if (cap !== 16'h0100) $display("FAIL in8_capture actual=%h required=0100", cap);
        else n_pass++;
        r_in = 8'h00;
        idle(1);
    endtask

    task automatic test_hold;
        logic [15:0] cap;
        logic [15:0] w;
        xfer(16'h1b14, cap);
        n_total++;
        if ({w_out, w_seg} !== 16'h1b14) $display("FAIL hold_first actual=%h required=1b14", {w_out, w_seg});
        else n_pass++;
        w = 16'h5a5b;
        bus.ss = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            bus.mosi = w[i];
            @(negedge sclk);
            n_total++;
            if ({w_out, w_seg} !== 16'h1b14) $display("FAIL hold_bit%0d actual=%h required=1b14", i, {w_out, w_seg});
            else n_pass++;
        end
        end_xfer();
        n_total++;
        if ({w_out, w_seg} !== 16'h5a5b) $display("FAIL hold_latch actual=%h required=5a5b", {w_out, w_seg});
        else n_pass++;
    endtask

    task automatic test_abort;
        logic [15:0] cap;
        shift_bits(16'h000f, 4, cap);
        rst = 1'b1;
        bus.ss = 1'b1;
        idle(2);
        rst = 1'b0;
        n_total++;
        if ({w_out, w_seg, w_sc, 7'h0, bus.miso} !== 32'h0) $display("FAIL abort_regs actual out=%h seg=%h sc=%h miso=%b required all 0", w_out, w_seg, w_sc, bus.miso);
        else n_pass++;
        idle(3);
        n_total++;
        if ({w_out, w_seg} !== 16'h0000) $display("FAIL abort_no_latch actual=%h required=0000", {w_out, w_seg});
        else n_pass++;
    endtask

    task automatic test_short;
        logic [15:0] cap;
        shift_bits(16'h000a, 4, cap);
        end_xfer();
        n_total++;
        if ({w_out, w_seg} !== 16'h000a) $display("FAIL short_xfer actual=%h required=000a", {w_out, w_seg});
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        pwm = 1'b1;
        r_in = 8'h00;
        bus.ss = 1'b1;
        bus.mosi = 1'b0;
        @(negedge sclk);
        test_reset();
        test_word();
        test_pwm();
        test_inputs();
        test_hold();
        test_abort();
        test_short();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
